tx_mbox_sched: RTL
==================

TX_MBOX_SCHED -- requirements
Module: tx_mbox_sched

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 8: error-abort attempts allowed per mailbox before failure; valid range 1..15.
REQ-002 SHALL have ports clk (input, 1): clock; g_rst (input, 1): reset, asynchronous, active-high.
REQ-003 SHALL have mb_req (input, 4): per-mailbox transmit request, level, set and cleared by host.
REQ-004 SHALL have mb_id (input, 44): four 11-bit priority IDs, mailbox i at bits [11i+10:11i].
REQ-005 SHALL have mb_abort (input, 4): per-mailbox host abort request, level.
REQ-006 SHALL have bus_idle (input, 1): start of frame permitted; bus_off_sts (input, 1): node bus-off.
REQ-007 SHALL have tx_ok (input, 1): frame completed and acknowledged; arb_lost (input, 1): arbitration lost; abort_dt_rm_tx (input, 1): frame aborted by error or overload. Each is a 1-cycle pulse.
REQ-008 SHALL have dt_rm_frm_tx (output, 1): data/remote frame transmit request to the frame transmitter.
REQ-009 SHALL have tx_sel (output, 2): active mailbox index; tx_id (output, 11): active mailbox ID.
REQ-010 SHALL have mb_done (output, 4) and mb_fail (output, 4): 1-cycle completion pulses per mailbox.

Function
REQ-011 SHALL implement states IDLE and ACTIVE.
REQ-012 Eligible mailbox i: mb_req[i] & ~mb_abort[i] & ~mask[i]; mask is an internal 4-bit register.
REQ-013 Winner: lowest mb_id among eligible mailboxes; on equal IDs, lowest index wins.
REQ-014 IDLE -> ACTIVE when bus_idle & ~bus_off_sts & any eligible: latch winner into tx_sel and tx_id; dt_rm_frm_tx rises on the next edge (1-cycle latency).
REQ-015 In ACTIVE, dt_rm_frm_tx SHALL stay 1 and tx_sel/tx_id SHALL stay constant; mb_id and mb_req changes SHALL be ignored.
REQ-016 ACTIVE + tx_ok: mb_done[tx_sel] pulses; set mask[tx_sel]; clear retry count; dt_rm_frm_tx = 0; go to IDLE.
REQ-017 ACTIVE + arb_lost: dt_rm_frm_tx = 0; go to IDLE; retry count unchanged; mailbox stays eligible for re-arbitration.
REQ-018 ACTIVE + abort_dt_rm_tx: increment retry count; dt_rm_frm_tx = 0; go to IDLE.
REQ-019 If an attempt ends with arb_lost or abort_dt_rm_tx while mb_abort[tx_sel]=1: mb_fail[tx_sel] pulses; set mask[tx_sel]. A frame in progress SHALL never be cut short by mb_abort.
REQ-020 ACTIVE + bus_off_sts: dt_rm_frm_tx = 0 next cycle; go to IDLE; no done/fail pulse; clear retry count; masks unchanged.
REQ-021 Simultaneous-event priority: bus_off_sts > abort_dt_rm_tx > tx_ok > arb_lost.
REQ-022 mask[i] SHALL clear one cycle after mb_req[i] is seen low; mb_done and mb_fail SHALL never pulse together.
REQ-023 Retry count is 4-bit and saturating; clear it whenever the latched winner index differs from the previous tx_sel.

Reset
REQ-024 On g_rst: state IDLE; dt_rm_frm_tx=0, tx_sel=0, tx_id=0, mb_done=0, mb_fail=0, mask=0, retry count=0; takes effect mid-frame with no pulses.

Configuration
REQ-025 Macro TX_RETRY_LIMIT_EN defined: when retry count reaches RETRY_MAX on abort_dt_rm_tx, mb_fail[tx_sel] pulses, mask[tx_sel] is set and the count clears.
REQ-026 Macro TX_RETRY_LIMIT_EN undefined: no retry counter exists, retransmission is unlimited, and mb_fail is driven only by REQ-019.

Structure
REQ-027 Package can_tx_pkg SHALL hold the state encoding, N_MB=4, ID_W=11 and the RETRY_MAX default.
REQ-028 Sub-module id_min_sel: combinational lowest-ID/lowest-index selector over eligible mailboxes, returning a valid flag and the winner index.

Verification
REQ-029 mb_req=0101, id0=0x123, id2=0x045, bus_idle=1 -> tx_sel=2, tx_id=0x045, dt_rm_frm_tx=1 one cycle later.
REQ-030 Equal IDs 0x100 on mailboxes 1 and 3 -> tx_sel=1; tx_ok -> mb_done=0010 for one cycle; mailbox 1 not reselected until mb_req[1] toggles.
REQ-031 arb_lost during mailbox 0 while mailbox 3 has a lower ID -> IDLE, then tx_sel=3 on the next bus_idle; no pulse on mailbox 0.
REQ-032 With TX_RETRY_LIMIT_EN and RETRY_MAX=3: three abort_dt_rm_tx on the same mailbox -> mb_fail pulse on the third; without the macro -> fourth attempt starts.
REQ-033 Same cycle bus_off_sts=1 and tx_ok=1 -> no mb_done pulse, dt_rm_frm_tx=0; g_rst mid-ACTIVE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/can_tx_pkg.sv
// can_tx_pkg: shared types and constants for the CAN transmit mailbox scheduler.
package can_tx_pkg;

  localparam int N_MB          = 4;
  localparam int ID_W          = 11;
  localparam int SEL_W         = 2;
  localparam int RETRY_MAX_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // One-hot mailbox vector for a mailbox index.
  function automatic logic [N_MB-1:0] mb_onehot(input logic [SEL_W-1:0] idx);
    logic [N_MB-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // 4-bit saturating increment used by the retry counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'h1;
  endfunction

endpackage

// File: rtl/id_min_sel.sv
// id_min_sel: combinational winner selection over eligible mailboxes.
// Lowest ID wins; equal IDs resolve to the lowest mailbox index because the
// scan runs upward and only a strictly smaller ID replaces the current best.
module id_min_sel
  import can_tx_pkg::*;
(
  input  logic [N_MB-1:0]      elig,
  input  logic [N_MB*ID_W-1:0] ids,
  output logic                 valid,
  output logic [SEL_W-1:0]     win_idx,
  output logic [ID_W-1:0]      win_id
);

  // Upward scan keeping the best (lowest ID, lowest index) eligible mailbox.
  always_comb begin
    valid   = 1'b0;
    win_idx = '0;
    win_id  = '0;
    for (int i = 0; i < N_MB; i++) begin
      if (elig[i] && (!valid || (ids[i*ID_W +: ID_W] < win_id))) begin
        valid   = 1'b1;
        win_idx = SEL_W'(i);
        win_id  = ids[i*ID_W +: ID_W];
      end else begin
        // current best is kept
      end
    end
  end

endmodule

// File: rtl/tx_mbox_sched.sv
// tx_mbox_sched: four-mailbox CAN transmit scheduler.
// Picks the lowest-ID eligible mailbox when the bus is idle, holds the request
// to the frame transmitter until the attempt ends, and reports per-mailbox
// completion (mb_done) or failure (mb_fail) with one-cycle pulses.
// Optional feature: define TX_RETRY_LIMIT_EN to fail a mailbox after RETRY_MAX
// error-aborted attempts; without it retransmission is unlimited.
module tx_mbox_sched
  import can_tx_pkg::*;
#(
  parameter int RETRY_MAX = RETRY_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 g_rst,
  input  logic [N_MB-1:0]      mb_req,
  input  logic [N_MB*ID_W-1:0] mb_id,
  input  logic [N_MB-1:0]      mb_abort,
  input  logic                 bus_idle,
  input  logic                 bus_off_sts,
  input  logic                 tx_ok,
  input  logic                 arb_lost,
  input  logic                 abort_dt_rm_tx,
  output logic                 dt_rm_frm_tx,
  output logic [SEL_W-1:0]     tx_sel,
  output logic [ID_W-1:0]      tx_id,
  output logic [N_MB-1:0]      mb_done,
  output logic [N_MB-1:0]      mb_fail
);

  // The retry counter is 4 bits wide, so the limit must fit 1..15.
  if ((RETRY_MAX < 1) || (RETRY_MAX > 15)) begin : g_bad_retry_max
    $error("tx_mbox_sched: RETRY_MAX must be within 1..15");
  end

  tx_state_e        state_r, state_nxt_s;
  logic [SEL_W-1:0] tx_sel_r, sel_nxt_s;
  logic [ID_W-1:0]  tx_id_r, id_nxt_s;
  logic             dt_r;
  logic [N_MB-1:0]  done_r, done_nxt_s;
  logic [N_MB-1:0]  fail_r, fail_nxt_s;
  logic [N_MB-1:0]  mask_r, mask_set_s, mask_nxt_s;
  logic [N_MB-1:0]  elig_s;
  logic             win_vld_s;
  logic [SEL_W-1:0] win_idx_s;
  logic [ID_W-1:0]  win_id_s;

`ifdef TX_RETRY_LIMIT_EN
  localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);
  logic [3:0] retry_r, retry_nxt_s, retry_inc_s;
  assign retry_inc_s = sat_inc4(retry_r);
`endif

  assign elig_s = mb_req & ~mb_abort & ~mask_r;

  id_min_sel u_id_min_sel (
    .elig    (elig_s),
    .ids     (mb_id),
    .valid   (win_vld_s),
    .win_idx (win_idx_s),
    .win_id  (win_id_s)
  );

  // A served or failed mailbox stays masked until the host drops its request.
  assign mask_nxt_s = (mask_r & mb_req) | mask_set_s;

  // Next-state, latch and pulse decode; bus-off > error abort > tx_ok > arb_lost.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = tx_sel_r;
    id_nxt_s    = tx_id_r;
    done_nxt_s  = '0;
    fail_nxt_s  = '0;
    mask_set_s  = '0;
`ifdef TX_RETRY_LIMIT_EN
    retry_nxt_s = retry_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus_idle && !bus_off_sts && win_vld_s) begin
          state_nxt_s = ST_ACTIVE;
          sel_nxt_s   = win_idx_s;
          id_nxt_s    = win_id_s;
`ifdef TX_RETRY_LIMIT_EN
          if (win_idx_s != tx_sel_r) begin
            retry_nxt_s = 4'h0;
          end else begin
            retry_nxt_s = retry_r;
          end
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (bus_off_sts) begin
          state_nxt_s = ST_IDLE;
`ifdef TX_RETRY_LIMIT_EN
          retry_nxt_s = 4'h0;
`endif
        end else if (abort_dt_rm_tx) begin
          state_nxt_s = ST_IDLE;
`ifdef TX_RETRY_LIMIT_EN
          if (mb_abort[tx_sel_r] || (retry_inc_s >= RETRY_LIM)) begin
            fail_nxt_s  = mb_onehot(tx_sel_r);
            mask_set_s  = mb_onehot(tx_sel_r);
            retry_nxt_s = 4'h0;
          end else begin
            retry_nxt_s = retry_inc_s;
          end
`else
          if (mb_abort[tx_sel_r]) begin
            fail_nxt_s = mb_onehot(tx_sel_r);
            mask_set_s = mb_onehot(tx_sel_r);
          end else begin
            fail_nxt_s = '0;
          end
`endif
        end else if (tx_ok) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = mb_onehot(tx_sel_r);
          mask_set_s  = mb_onehot(tx_sel_r);
`ifdef TX_RETRY_LIMIT_EN
          retry_nxt_s = 4'h0;
`endif
        end else if (arb_lost) begin
          state_nxt_s = ST_IDLE;
          if (mb_abort[tx_sel_r]) begin
            fail_nxt_s = mb_onehot(tx_sel_r);
            mask_set_s = mb_onehot(tx_sel_r);
          end else begin
            fail_nxt_s = '0;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched winner, masks and registered output pulses.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_r  <= ST_IDLE;
      tx_sel_r <= '0;
      tx_id_r  <= '0;
      dt_r     <= 1'b0;
      done_r   <= '0;
      fail_r   <= '0;
      mask_r   <= '0;
    end else begin
      state_r  <= state_nxt_s;
      tx_sel_r <= sel_nxt_s;
      tx_id_r  <= id_nxt_s;
      dt_r     <= (state_nxt_s == ST_ACTIVE);
      done_r   <= done_nxt_s;
      fail_r   <= fail_nxt_s;
      mask_r   <= mask_nxt_s;
    end
  end

`ifdef TX_RETRY_LIMIT_EN
  // Error-abort retry counter for the currently latched mailbox.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      retry_r <= 4'h0;
    end else begin
      retry_r <= retry_nxt_s;
    end
  end
`endif

  assign dt_rm_frm_tx = dt_r;
  assign tx_sel       = tx_sel_r;
  assign tx_id        = tx_id_r;
  assign mb_done      = done_r;
  assign mb_fail      = fail_r;

endmodule
